// File: rtl/periph_rd_mux_pkg.sv
// Shared definitions for the peripheral read-return path: FSM encodings,
// the word returned on failed reads, and the decoder's channel map.
package periph_rd_mux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_e;

    // Recognisable filler so a core reading a dead or illegal address sees a pattern.
    localparam logic [31:0] DEFAULT_RDATA = 32'h66666666;

    localparam int CH_RAM   = 0;
    localparam int CH_UART  = 1;
    localparam int CH_GPIO  = 2;
    localparam int CH_MULT  = 3;
    localparam int CH_DIV   = 4;
    localparam int CH_BCD   = 5;
    localparam int CH_DPRAM = 6;

endpackage

// File: rtl/periph_rd_mux_onehot_enc.sv
// One-hot to binary index encoder with a legality flag; shared with the
// address decoder checks.
module periph_rd_mux_onehot_enc #(
    parameter int N  = 8,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  onehot_i,
    output logic [IW-1:0] idx_o,
    output logic          is_onehot_o
);

    // OR-reduction: each set bit contributes its own index; exact only when one-hot.
    always_comb begin
        idx_o = '0;
        for (int i = 0; i < N; i++) begin
            if (onehot_i[i]) begin
                idx_o = idx_o | IW'(i);
            end
        end
    end

    assign is_onehot_o = (onehot_i != '0) && ((onehot_i & (onehot_i - N'(1))) == '0);

endmodule

// File: rtl/periph_rd_mux.sv
// Read-return multiplexer between the core read port and NCH peripherals,
// with per-slave wait states, illegal-select detection and a hung-slave timeout.
module periph_rd_mux
    import periph_rd_mux_pkg::*;
#(
    parameter int              NCH          = 8,
    parameter int              DW           = 32,
    parameter int              TIMEOUT      = 15,
    parameter logic [DW-1:0]   DEFAULT_DATA = DEFAULT_RDATA
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              rd_req,
    input  logic [NCH-1:0]    cs,
    input  logic [NCH*DW-1:0] slv_rdata,
    input  logic [NCH-1:0]    slv_ready,
    output logic [DW-1:0]     mem_rdata,
    output logic              mem_rbusy,
    output logic              err_flag,
    output logic              err_timeout,
    output logic [NCH-1:0]    err_cs,
    input  logic              err_clr,
    output logic [1:0]        dbg_state_o
);

    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    state_e          state_q;
    logic [NCH-1:0]  cs_q;
    logic [CW-1:0]   cnt_q;
    logic [DW-1:0]   rdata_q;
    logic            err_flag_q;
    logic            err_timeout_q;
    logic [NCH-1:0]  err_cs_q;

    logic [NCH-1:0]  enc_in;
    logic [IW-1:0]   sel_idx;
    logic            enc_onehot;
    logic [DW-1:0]   sel_rdata;
    logic            sel_ready;

    // Legality is only judged on the incoming cs in IDLE; afterwards the
    // encoder indexes the captured cs_q, so one encoder serves both roles.
    assign enc_in = (state_q == ST_IDLE) ? cs : cs_q;

    periph_rd_mux_onehot_enc #(
        .N  (NCH),
        .IW (IW)
    ) u_enc (
        .onehot_i    (enc_in),
        .idx_o       (sel_idx),
        .is_onehot_o (enc_onehot)
    );

    assign sel_rdata = slv_rdata[sel_idx*DW +: DW];
    assign sel_ready = slv_ready[sel_idx];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            cs_q          <= '0;
            cnt_q         <= '0;
            rdata_q       <= '0;
            err_flag_q    <= 1'b0;
            err_timeout_q <= 1'b0;
            err_cs_q      <= '0;
        end else begin
            // Clear first so an error captured in the same cycle overrides it.
            if (err_clr) begin
                err_flag_q    <= 1'b0;
                err_timeout_q <= 1'b0;
                err_cs_q      <= '0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (rd_req) begin
                        cs_q  <= cs;
                        cnt_q <= '0;
                        state_q <= enc_onehot ? ST_WAIT : ST_ERR;
                    end
                end
                ST_WAIT: begin
                    if (sel_ready) begin
                        rdata_q <= sel_rdata;
                        state_q <= ST_IDLE;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        rdata_q       <= DEFAULT_DATA;
                        err_flag_q    <= 1'b1;
                        err_timeout_q <= 1'b1;
                        err_cs_q      <= cs_q;
                        state_q       <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_ERR: begin
                    rdata_q       <= DEFAULT_DATA;
                    err_flag_q    <= 1'b1;
                    err_timeout_q <= 1'b0;
                    err_cs_q      <= cs_q;
                    state_q       <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_rbusy   = (state_q == ST_WAIT) || (state_q == ST_ERR);
    assign mem_rdata   = rdata_q;
    assign err_flag    = err_flag_q;
    assign err_timeout = err_timeout_q;
    assign err_cs      = err_cs_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_periph_rd_mux.sv
// Randomised read-transaction bench for periph_rd_mux with a transaction-level
// reference model and a per-cycle compare process.
module tb_periph_rd_mux;

    localparam int          NCH     = 8;
    localparam int          DW      = 32;
    localparam int          TIMEOUT = 15;
    localparam logic [31:0] DEF     = 32'h66666666;

    logic              clk = 1'b0;
    logic              resetn;
    logic              rd_req;
    logic [NCH-1:0]    cs;
    logic [NCH*DW-1:0] slv_rdata;
    logic [NCH-1:0]    slv_ready;
    logic [DW-1:0]     mem_rdata;
    logic              mem_rbusy;
    logic              err_flag;
    logic              err_timeout;
    logic [NCH-1:0]    err_cs;
    logic              err_clr;
    logic [1:0]        dbg_state;

    periph_rd_mux #(
        .NCH     (NCH),
        .DW      (DW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .rd_req      (rd_req),
        .cs          (cs),
        .slv_rdata   (slv_rdata),
        .slv_ready   (slv_ready),
        .mem_rdata   (mem_rdata),
        .mem_rbusy   (mem_rbusy),
        .err_flag    (err_flag),
        .err_timeout (err_timeout),
        .err_cs      (err_cs),
        .err_clr     (err_clr),
        .dbg_state_o (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // model state (transaction level)
    bit             chk_en = 1'b0;
    logic           exp_busy;
    logic [1:0]     exp_state;
    logic [DW-1:0]  exp_rdata;
    logic           exp_flag;
    logic           exp_to;
    logic [NCH-1:0] exp_ecs;
    logic [DW-1:0]  exp_q[$];
    logic           prev_busy = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_busy  = 1'b0;
        exp_state = 2'd0;
        exp_rdata = '0;
        exp_flag  = 1'b0;
        exp_to    = 1'b0;
        exp_ecs   = '0;
        exp_q.delete();
    endtask

    task automatic model_clear_err();
        exp_flag = 1'b0;
        exp_to   = 1'b0;
        exp_ecs  = '0;
    endtask

    // compare process: every cycle, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("rbusy", mem_rbusy, exp_busy);
            chk("state", dbg_state, exp_state);
            chk("rdata", mem_rdata, exp_rdata);
            chk("err_flag", err_flag, exp_flag);
            chk("err_timeout", err_timeout, exp_to);
            chk("err_cs", err_cs, exp_ecs);
            if (resetn && prev_busy && !mem_rbusy) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_underflow: read completed with no expected entry at %0t", $time);
                end else begin
                    chk("sb_rdata", mem_rdata, exp_q.pop_front());
                end
            end
        end
        prev_busy = mem_rbusy;
    end

    // driver tasks
    task automatic rand_bus(input int sel, input logic [DW-1:0] d, input logic rdy);
        for (int i = 0; i < NCH; i++) slv_rdata[i*DW +: DW] = $urandom;
        slv_rdata[sel*DW +: DW] = d;
        slv_ready = NCH'($urandom);
        slv_ready[sel] = rdy;
    endtask

    // k = WAIT cycles with the selected ready low before it rises.
    task automatic do_read(input logic [NCH-1:0] c, input int k, input logic [DW-1:0] d,
                           input bit clr_end, output int obs);
        bit            legal;
        bit            tmo;
        int            sel;
        int            busy;
        logic [DW-1:0] res;
        legal = ($countones(c) == 1);
        sel = 0;
        for (int i = 0; i < NCH; i++) if (c[i]) sel = i;
        tmo  = legal && (k + 1 > TIMEOUT);
        busy = !legal ? 1 : (tmo ? TIMEOUT : k + 1);
        res  = (!legal || tmo) ? DW'(DEF) : d;
        exp_q.push_back(res);
        rd_req  = 1'b1;
        cs      = c;
        err_clr = 1'b0;
        rand_bus(sel, d, 1'b0);
        obs = 0;
        for (int j = 0; j <= busy; j++) begin
            @(posedge clk);
            #1;
            obs += int'(mem_rbusy);
            if (j < busy) begin
                exp_busy  = 1'b1;
                exp_state = legal ? 2'd1 : 2'd2;
                rd_req    = 1'($urandom_range(0, 1));
                cs        = NCH'($urandom);
                err_clr   = (j == busy - 1) ? clr_end : 1'b0;
                rand_bus(sel, d, (j + 1) > k);
            end else begin
                exp_busy  = 1'b0;
                exp_state = 2'd0;
                exp_rdata = res;
                if (!legal || tmo) begin
                    exp_flag = 1'b1;
                    exp_to   = tmo;
                    exp_ecs  = c;
                end else if (clr_end) begin
                    model_clear_err();
                end
                rd_req  = 1'b0;
                err_clr = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n, input bit rand_clr);
        for (int i = 0; i < n; i++) begin
            rd_req  = 1'b0;
            cs      = NCH'($urandom);
            err_clr = rand_clr && ($urandom_range(0, 3) == 0);
            rand_bus(0, DW'($urandom), 1'($urandom_range(0, 1)));
            @(posedge clk);
            #1;
            if (err_clr) model_clear_err();
        end
        err_clr = 1'b0;
    endtask

    task automatic clear_pulse();
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        model_clear_err();
        err_clr = 1'b0;
    endtask

    initial begin
        int             obs;
        logic [NCH-1:0] c;
        int             k;
        int             r;

        resetn    = 1'b0;
        rd_req    = 1'b0;
        cs        = '0;
        err_clr   = 1'b0;
        slv_rdata = '0;
        slv_ready = '0;
        model_reset();
        chk_en = 1'b1;
        #2;
        chk("reset_rbusy", mem_rbusy, 0);
        chk("reset_rdata", mem_rdata, 0);
        chk("reset_err_flag", err_flag, 0);
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;

        // zero-wait slave
        do_read(8'h01, 0, 32'h12345678, 1'b0, obs);
        chk("zw_busy_cycles", obs, 1);
        chk("zw_rdata", mem_rdata, 32'h12345678);
        chk("zw_err_flag", err_flag, 0);
        idle(2, 1'b0);

        // three wait states
        do_read(8'h20, 3, 32'hCAFEF00D, 1'b0, obs);
        chk("ws_busy_cycles", obs, 4);
        chk("ws_rdata", mem_rdata, 32'hCAFEF00D);
        chk("ws_err_flag", err_flag, 0);
        idle(1, 1'b0);

        // hung slave
        do_read(8'h04, 100, 32'h0BADBEEF, 1'b0, obs);
        chk("to_busy_cycles", obs, 15);
        chk("to_rdata", mem_rdata, 32'h66666666);
        chk("to_err_flag", err_flag, 1);
        chk("to_err_timeout", err_timeout, 1);
        chk("to_err_cs", err_cs, 8'h04);
        idle(1, 1'b0);

        // illegal selects
        do_read(8'h00, 0, 32'h11111111, 1'b0, obs);
        chk("ill0_busy_cycles", obs, 1);
        chk("ill0_rdata", mem_rdata, 32'h66666666);
        chk("ill0_err_timeout", err_timeout, 0);
        do_read(8'h11, 0, 32'h22222222, 1'b0, obs);
        chk("ill1_busy_cycles", obs, 1);
        chk("ill1_err_cs", err_cs, 8'h11);
        clear_pulse();
        chk("clr_err_flag", err_flag, 0);
        chk("clr_err_timeout", err_timeout, 0);
        chk("clr_err_cs", err_cs, 0);
        chk("clr_rdata_held", mem_rdata, 32'h66666666);

        // timeout expiring on the same edge as err_clr
        do_read(8'h04, 100, 32'h33333333, 1'b1, obs);
        chk("sim_err_flag", err_flag, 1);
        chk("sim_err_timeout", err_timeout, 1);
        idle(2, 1'b0);

        // randomised traffic
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 9) < 7) begin
                c = '0;
                c[$urandom_range(0, NCH - 1)] = 1'b1;
            end else begin
                c = NCH'($urandom_range(0, 255));
            end
            r = $urandom_range(0, 9);
            if (r < 4)      k = 0;
            else if (r < 8) k = $urandom_range(1, 6);
            else            k = $urandom_range(12, 20);
            do_read(c, k, DW'($urandom), ($urandom_range(0, 3) == 0), obs);
            idle($urandom_range(0, 3), 1'b1);
        end

        // reset in the middle of a read
        rd_req    = 1'b1;
        cs        = 8'h02;
        slv_ready = '0;
        @(posedge clk);
        #1;
        rd_req    = 1'b0;
        exp_busy  = 1'b1;
        exp_state = 2'd1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        resetn = 1'b0;
        model_reset();
        #1;
        chk("rst_mid_rbusy", mem_rbusy, 0);
        chk("rst_mid_rdata", mem_rdata, 0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        do_read(8'h01, 2, 32'hA5A50001, 1'b0, obs);
        chk("post_rst_busy_cycles", obs, 3);
        chk("post_rst_rdata", mem_rdata, 32'hA5A50001);
        idle(2, 1'b0);

        chk("sb_drained", exp_q.size(), 0);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/periph_rd_mux.md
Name: periph_rd_mux

Overview:
- Parametrised read-return multiplexer between the femtoriscv core read port and NCH memory-mapped peripherals (DPRAM, UART, GPIO, mult, div, bin2bcd, RAM, ...).
- Unlike the plain combinational select, it honours per-peripheral wait states via a ready handshake and drives the core's mem_rbusy.
- It registers the returned word and detects illegal chip-selects and hung slaves with a timeout.
- It sits between the address decoder (one-hot cs) and the core's mem_rdata/mem_rbusy inputs.

Parameters:
NCH, 8, number of peripheral channels (one cs bit each; bit NCH-1 is the highest-priority-decoded region, no priority used here)
DW, 32, data width
TIMEOUT, 15, max cycles spent in WAIT before forced error return (1..255)
DEFAULT_DATA, 32'h66666666, word returned on illegal cs or timeout

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
rd_req  input  1  core read strobe, one-cycle pulse, sampled with cs
cs  input  NCH  one-hot chip-select from address decoder
slv_rdata  input  NCH*DW  concatenated peripheral read data, channel i at [i*DW +: DW]
slv_ready  input  NCH  per-channel data-valid; tie high for zero-wait slaves
mem_rdata  output  DW  registered read data to core
mem_rbusy  output  1  high while a read is outstanding
err_flag  output  1  sticky error flag
err_timeout  output  1  sticky: last error was a timeout (0 = illegal cs)
err_cs  output  NCH  cs value captured at the last error
err_clr  input  1  clears err_flag/err_timeout/err_cs

Behaviour:
- Reset (async, resetn low): state IDLE, mem_rdata=0, mem_rbusy=0, err_flag=0, err_timeout=0, err_cs=0, timeout counter=0, cs_q=0. Reset mid-read abandons the read; no data is returned.
- FSM states: IDLE, WAIT, ERR.
- IDLE, rd_req=1, cs one-hot: latch cs_q<=cs, counter<=0 -> WAIT.
- IDLE, rd_req=1, cs zero or multi-hot: cs_q<=cs -> ERR.
- IDLE, rd_req=0: stay.
- WAIT:
  - mem_rbusy=1 (combinational, state==WAIT or ERR).
  - Each cycle, select the channel indexed by cs_q.
  - If slv_ready[sel]=1: mem_rdata<=slv_rdata[sel] -> IDLE.
  - Else if counter==TIMEOUT-1: mem_rdata<=DEFAULT_DATA, err_flag<=1, err_timeout<=1, err_cs<=cs_q -> IDLE.
  - Else counter++.
  - cs and slv_rdata of non-selected channels are don't-care. rd_req is ignored.
- ERR: mem_rdata<=DEFAULT_DATA, err_flag<=1, err_timeout<=0, err_cs<=cs_q -> IDLE. Always one cycle.
- Latency (rd_req at edge 0):
  - mem_rbusy is high from cycle 1.
  - A zero-wait slave (ready high) yields mem_rdata valid and mem_rbusy low in cycle 2.
  - k wait cycles add k.
  - Timeout yields valid DEFAULT_DATA after TIMEOUT busy cycles.
- mem_rdata holds its value until the next completed read; it never changes while in IDLE.
- err_clr and a new error in the same cycle: the set wins and the new error fields are captured.
- err_clr while no error: no effect. Error fields are overwritten by each new error (last-error semantics).
- Counter width: $clog2(TIMEOUT+1); it never wraps because the transition occurs at TIMEOUT-1.
- Channel index: computed from one-hot cs_q by an OR-reduction encoder. Legality is checked at IDLE only.

Decomposition:
- Shared package/include periph_pkg.vh holds:
  - state encodings (ST_IDLE=2'd0, ST_WAIT=2'd1, ST_ERR=2'd2)
  - DEFAULT_DATA
  - the channel index constants used by the address decoder (CH_RAM=0 ... CH_DPRAM=6)
- One sub-module: onehot_enc (NCH-wide one-hot to index plus is_onehot flag). It is combinational and is reused by the address decoder checks.

Test Plan:
- Zero-wait: NCH=8, cs=8'h01, ready=8'hFF, slv0=32'h12345678, rd_req pulse -> mem_rbusy high 1 cycle; mem_rdata=32'h12345678 in cycle 2; err_flag=0.
- Wait states: cs=8'h20, slv_ready[5] rises after 3 cycles with data 32'hCAFEF00D -> mem_rbusy high 4 cycles; mem_rdata=32'hCAFEF00D; no error.
- Timeout: cs=8'h04, slv_ready=0 -> after 15 busy cycles, mem_rdata=32'h66666666, err_flag=1, err_timeout=1, err_cs=8'h04.
- Illegal cs: cs=8'h00, then cs=8'h11 -> each returns 32'h66666666 after 1 busy cycle, err_timeout=0, err_cs=8'h11 after the second; err_clr pulse -> all error outputs 0.
- Reset mid-read: cs=8'h02, ready low, resetn low in cycle 3 -> mem_rbusy=0 and mem_rdata=0 immediately (async); after release, a fresh read on cs=8'h01 completes normally.
- Simultaneous: timeout expiry in the same cycle as err_clr -> err_flag=1 afterwards.
